rv32i_decode: RTL and testbench

//  RV32I decode stage; sits directly downstream of rv32i_fetch and feeds execute.

---
 rtl/rv32i_decode_pkg.sv | 76 +++++++
 rtl/rv32i_decode_if.sv | 38 +++
 rtl/rv32i_decode_regfile.sv | 32 +++
 rtl/rv32i_decode.sv | 95 +++++++++
 tb/tb_rv32i_decode.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/rv32i_decode_pkg.sv
// rtl/rv32i_decode_pkg.sv - RV32I opcodes, immediate classes, decoded bundle and immediate helpers
package rv32i_decode_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_NONE
    } imm_type_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic        illegal;
    } decoded_t;

    function automatic logic is_legal(input logic [6:0] op);
        logic known;
        case (op)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD,
            OP_STORE, OP_IMM, OP_OP, OP_FENCE, OP_SYSTEM: known = 1'b1;
            default:                                      known = 1'b0;
        endcase
        return known && (op[1:0] == 2'b11);
    endfunction

    // Unknown opcodes fall to IMM_NONE so illegal instructions carry a zero immediate.
    function automatic imm_type_e imm_type_of(input logic [6:0] op);
        imm_type_e t;
        case (op)
            OP_IMM, OP_LOAD, OP_JALR: t = IMM_I;
            OP_STORE:                 t = IMM_S;
            OP_BRANCH:                t = IMM_B;
            OP_LUI, OP_AUIPC:         t = IMM_U;
            OP_JAL:                   t = IMM_J;
            default:                  t = IMM_NONE;
        endcase
        return t;
    endfunction

    function automatic logic [31:0] gen_imm(input logic [31:0] instr);
        logic [31:0] imm;
        case (imm_type_of(instr[6:0]))
            IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm = {instr[31:12], 12'h000};
            IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = 32'h0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/rv32i_decode_if.sv
// rtl/rv32i_decode_if.sv - fetch, writeback and execute-side signals of the decode stage
interface rv32i_decode_if #(
    parameter int XLEN = 32
);
    logic            i_valid;
    logic            o_ready;
    logic [XLEN-1:0] i_pc;
    logic [XLEN-1:0] i_instr;
    logic            i_flush;
    logic            i_wb_en;
    logic [4:0]      i_wb_rd;
    logic [XLEN-1:0] i_wb_data;
    logic            o_valid;
    logic            i_ready;
    logic [XLEN-1:0] o_pc;
    logic [6:0]      o_opcode;
    logic [2:0]      o_funct3;
    logic [6:0]      o_funct7;
    logic [4:0]      o_rs1;
    logic [4:0]      o_rs2;
    logic [4:0]      o_rd;
    logic [XLEN-1:0] o_rs1_data;
    logic [XLEN-1:0] o_rs2_data;
    logic [XLEN-1:0] o_imm;
    logic            o_illegal;

    modport master (
        input  i_valid, i_pc, i_instr, i_flush, i_wb_en, i_wb_rd, i_wb_data, i_ready,
        output o_ready, o_valid, o_pc, o_opcode, o_funct3, o_funct7, o_rs1, o_rs2, o_rd,
               o_rs1_data, o_rs2_data, o_imm, o_illegal
    );

    modport slave (
        output i_valid, i_pc, i_instr, i_flush, i_wb_en, i_wb_rd, i_wb_data, i_ready,
        input  o_ready, o_valid, o_pc, o_opcode, o_funct3, o_funct7, o_rs1, o_rs2, o_rd,
               o_rs1_data, o_rs2_data, o_imm, o_illegal
    );
endinterface

// File: rtl/rv32i_decode_regfile.sv
// rtl/rv32i_decode_regfile.sv - 32x32 architectural register file, 2 async reads, 1 write, x0 hardwired
module rv32i_decode_regfile #(
    parameter int          XLEN    = 32,
    parameter logic [31:0] SP_INIT = 32'h0000_1FFC
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [4:0]      rs1_addr,
    output logic [XLEN-1:0] rs1_data,
    input  logic [4:0]      rs2_addr,
    output logic [XLEN-1:0] rs2_data,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data
);
    logic [XLEN-1:0] regs [32];

    // sp starts at the top of RAM so early code can push without setup.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= (i == 2) ? SP_INIT[XLEN-1:0] : '0;
            end
        end else if (wb_en && (wb_rd != 5'd0)) begin
            regs[wb_rd] <= wb_data;
        end
    end

    assign rs1_data = (rs1_addr == 5'd0) ? '0 : regs[rs1_addr];
    assign rs2_data = (rs2_addr == 5'd0) ? '0 : regs[rs2_addr];

endmodule

// File: rtl/rv32i_decode.sv
// rtl/rv32i_decode.sv - RV32I decode stage: pipeline register, operand bypass/refresh, immediate generation
module rv32i_decode
    import rv32i_decode_pkg::*;
#(
    parameter int          XLEN    = 32,
    parameter logic [31:0] SP_INIT = 32'h0000_1FFC
) (
    input  logic           clk,
    input  logic           rst_n,
    rv32i_decode_if.master bus
);
    logic            accept;
    logic            out_valid;
    decoded_t        q;
    decoded_t        d;
    logic [4:0]      rs1_idx;
    logic [4:0]      rs2_idx;
    logic [XLEN-1:0] rf_rs1_data;
    logic [XLEN-1:0] rf_rs2_data;

    assign rs1_idx    = bus.i_instr[19:15];
    assign rs2_idx    = bus.i_instr[24:20];
    assign bus.o_ready = !out_valid || bus.i_ready;
    assign accept     = bus.i_valid && bus.o_ready;

    rv32i_decode_regfile #(
        .XLEN    (XLEN),
        .SP_INIT (SP_INIT)
    ) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .rs1_addr (rs1_idx),
        .rs1_data (rf_rs1_data),
        .rs2_addr (rs2_idx),
        .rs2_data (rf_rs2_data),
        .wb_en    (bus.i_wb_en),
        .wb_rd    (bus.i_wb_rd),
        .wb_data  (bus.i_wb_data)
    );

    // A writeback landing in the accept cycle is not yet visible in the array.
    always_comb begin
        d          = '0;
        d.pc       = bus.i_pc;
        d.opcode   = bus.i_instr[6:0];
        d.funct3   = bus.i_instr[14:12];
        d.funct7   = bus.i_instr[31:25];
        d.rs1      = rs1_idx;
        d.rs2      = rs2_idx;
        d.rd       = bus.i_instr[11:7];
        d.rs1_data = (bus.i_wb_en && (bus.i_wb_rd == rs1_idx) && (rs1_idx != 5'd0))
                     ? bus.i_wb_data : rf_rs1_data;
        d.rs2_data = (bus.i_wb_en && (bus.i_wb_rd == rs2_idx) && (rs2_idx != 5'd0))
                     ? bus.i_wb_data : rf_rs2_data;
        d.imm      = gen_imm(bus.i_instr);
        d.illegal  = !is_legal(bus.i_instr[6:0]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            q         <= '0;
        end else if (bus.i_flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            q         <= d;
        end else begin
            if (out_valid && bus.i_ready) begin
                out_valid <= 1'b0;
            end
            // Keep held operands coherent with writebacks that retire during a stall.
            if (out_valid && bus.i_wb_en && (bus.i_wb_rd == q.rs1) && (q.rs1 != 5'd0)) begin
                q.rs1_data <= bus.i_wb_data;
            end
            if (out_valid && bus.i_wb_en && (bus.i_wb_rd == q.rs2) && (q.rs2 != 5'd0)) begin
                q.rs2_data <= bus.i_wb_data;
            end
        end
    end

    assign bus.o_valid    = out_valid;
    assign bus.o_pc       = q.pc;
    assign bus.o_opcode   = q.opcode;
    assign bus.o_funct3   = q.funct3;
    assign bus.o_funct7   = q.funct7;
    assign bus.o_rs1      = q.rs1;
    assign bus.o_rs2      = q.rs2;
    assign bus.o_rd       = q.rd;
    assign bus.o_rs1_data = q.rs1_data;
    assign bus.o_rs2_data = q.rs2_data;
    assign bus.o_imm      = q.imm;
    assign bus.o_illegal  = q.illegal;

endmodule

// File: tb/tb_rv32i_decode.sv
// tb/tb_rv32i_decode.sv - directed self-checking bench for rv32i_decode
module tb_rv32i_decode;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    rv32i_decode_if dif ();

    rv32i_decode dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        dif.i_valid   = 1'b0;
        dif.i_pc      = 32'h0;
        dif.i_instr   = 32'h0;
        dif.i_flush   = 1'b0;
        dif.i_wb_en   = 1'b0;
        dif.i_wb_rd   = 5'd0;
        dif.i_wb_data = 32'h0;
        dif.i_ready   = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive_idle();
        tick();
        tick();
        total++; if (dif.o_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", dif.o_valid); end
        total++; if (dif.o_pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h want=0", dif.o_pc); end
        total++; if (dif.o_imm !== 32'h0) begin bad++; $display("FAIL reset_imm got=%h want=0", dif.o_imm); end
        total++; if (dif.o_rs1_data !== 32'h0) begin bad++; $display("FAIL reset_rs1_data got=%h want=0", dif.o_rs1_data); end
        total++; if (dif.o_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", dif.o_ready); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_sp_read();
        dif.i_valid = 1'b1;
        dif.i_pc    = 32'h0000_0100;
        dif.i_instr = 32'h0001_0093;
        tick();
        dif.i_valid = 1'b0;
        total++; if (dif.o_valid !== 1'b1) begin bad++; $display("FAIL sp_valid got=%b want=1", dif.o_valid); end
        total++; if (dif.o_rs1_data !== 32'h0000_1FFC) begin bad++; $display("FAIL sp_rs1_data got=%h want=00001ffc", dif.o_rs1_data); end
        total++; if (dif.o_imm !== 32'h0) begin bad++; $display("FAIL sp_imm got=%h want=0", dif.o_imm); end
        total++; if (dif.o_illegal !== 1'b0) begin bad++; $display("FAIL sp_illegal got=%b want=0", dif.o_illegal); end
        total++; if (dif.o_pc !== 32'h0000_0100) begin bad++; $display("FAIL sp_pc got=%h want=00000100", dif.o_pc); end
        total++; if ({dif.o_rs1, dif.o_rd, dif.o_opcode} !== {5'd2, 5'd1, 7'h13}) begin
            bad++; $display("FAIL sp_fields got=%0d/%0d/%h want=2/1/13", dif.o_rs1, dif.o_rd, dif.o_opcode);
        end
        tick();
        total++; if (dif.o_valid !== 1'b0) begin bad++; $display("FAIL consumed_valid got=%b want=0", dif.o_valid); end
    endtask

    task automatic test_bypass_and_stall();
        dif.i_valid   = 1'b1;
        dif.i_pc      = 32'h0000_0104;
        dif.i_instr   = 32'h0052_8333;
        dif.i_wb_en   = 1'b1;
        dif.i_wb_rd   = 5'd5;
        dif.i_wb_data = 32'hDEAD_BEEF;
        tick();
        dif.i_valid = 1'b0;
        dif.i_wb_en = 1'b0;
        total++; if (dif.o_rs1_data !== 32'hDEAD_BEEF) begin bad++; $display("FAIL bypass_rs1 got=%h want=deadbeef", dif.o_rs1_data); end
        total++; if (dif.o_rs2_data !== 32'hDEAD_BEEF) begin bad++; $display("FAIL bypass_rs2 got=%h want=deadbeef", dif.o_rs2_data); end
        total++; if ({dif.o_rd, dif.o_funct3, dif.o_funct7} !== {5'd6, 3'd0, 7'd0}) begin
            bad++; $display("FAIL add_fields got=%0d/%0d/%0d want=6/0/0", dif.o_rd, dif.o_funct3, dif.o_funct7);
        end
        dif.i_ready   = 1'b0;
        dif.i_wb_en   = 1'b1;
        dif.i_wb_rd   = 5'd5;
        dif.i_wb_data = 32'h0000_1234;
        #1;
        total++; if (dif.o_ready !== 1'b0) begin bad++; $display("FAIL stall_ready got=%b want=0", dif.o_ready); end
        tick();
        dif.i_wb_en = 1'b0;
        total++; if (dif.o_rs1_data !== 32'h0000_1234) begin bad++; $display("FAIL refresh_rs1 got=%h want=00001234", dif.o_rs1_data); end
        total++; if (dif.o_rs2_data !== 32'h0000_1234) begin bad++; $display("FAIL refresh_rs2 got=%h want=00001234", dif.o_rs2_data); end
        total++; if (dif.o_pc !== 32'h0000_0104) begin bad++; $display("FAIL stall_pc got=%h want=00000104", dif.o_pc); end
        dif.i_valid = 1'b1;
        dif.i_pc    = 32'h0000_0108;
        dif.i_instr = 32'h1234_5037;
        tick();
        tick();
        total++; if ({dif.o_valid, dif.o_pc, dif.o_opcode} !== {1'b1, 32'h0000_0104, 7'h33}) begin
            bad++; $display("FAIL stall_hold got=%b/%h/%h want=1/00000104/33", dif.o_valid, dif.o_pc, dif.o_opcode);
        end
        dif.i_valid = 1'b0;
        dif.i_ready = 1'b1;
        tick();
        total++; if (dif.o_valid !== 1'b0) begin bad++; $display("FAIL stall_release got=%b want=0", dif.o_valid); end
    endtask

    task automatic test_flush();
        dif.i_valid = 1'b1;
        dif.i_pc    = 32'h0000_0200;
        dif.i_instr = 32'h0001_0093;
        tick();
        total++; if (dif.o_valid !== 1'b1) begin bad++; $display("FAIL flush_pre_valid got=%b want=1", dif.o_valid); end
        dif.i_flush = 1'b1;
        dif.i_pc    = 32'h0000_0204;
        dif.i_instr = 32'h0052_8333;
        tick();
        dif.i_flush = 1'b0;
        dif.i_valid = 1'b0;
        total++; if (dif.o_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b want=0", dif.o_valid); end
        tick();
        total++; if (dif.o_valid !== 1'b0) begin bad++; $display("FAIL flush_dropped got=%b want=0", dif.o_valid); end
    endtask

    task automatic test_imm();
        logic [31:0] instrs [6];
        logic [31:0] imms [6];
        instrs[0] = 32'hFFDF_F0EF; imms[0] = 32'hFFFF_FFFC;
        instrs[1] = 32'hFE11_2E23; imms[1] = 32'hFFFF_FFFC;
        instrs[2] = 32'h1234_5037; imms[2] = 32'h1234_5000;
        instrs[3] = 32'hFE00_0CE3; imms[3] = 32'hFFFF_FFF8;
        instrs[4] = 32'hFFF0_0093; imms[4] = 32'hFFFF_FFFF;
        instrs[5] = 32'h0000_1097; imms[5] = 32'h0000_1000;
        for (int k = 0; k < 6; k++) begin
            dif.i_valid = 1'b1;
            dif.i_pc    = 32'h0000_0300 + 32'(k * 4);
            dif.i_instr = instrs[k];
            tick();
            total++; if ({dif.o_valid, dif.o_illegal, dif.o_imm} !== {1'b1, 1'b0, imms[k]}) begin
                bad++; $display("FAIL imm_%0d got=%b/%b/%h want=1/0/%h", k, dif.o_valid, dif.o_illegal, dif.o_imm, imms[k]);
            end
        end
        dif.i_valid = 1'b0;
        tick();
    endtask

    task automatic test_x0_and_illegal();
        dif.i_wb_en   = 1'b1;
        dif.i_wb_rd   = 5'd0;
        dif.i_wb_data = 32'h0000_0055;
        tick();
        dif.i_wb_en = 1'b0;
        dif.i_valid = 1'b1;
        dif.i_instr = 32'h0000_0093;
        tick();
        total++; if (dif.o_rs1_data !== 32'h0) begin bad++; $display("FAIL x0_read got=%h want=0", dif.o_rs1_data); end
        dif.i_instr = 32'h0000_007F;
        tick();
        total++; if ({dif.o_valid, dif.o_illegal, dif.o_imm} !== {1'b1, 1'b1, 32'h0}) begin
            bad++; $display("FAIL illegal_7f got=%b/%b/%h want=1/1/0", dif.o_valid, dif.o_illegal, dif.o_imm);
        end
        dif.i_instr = 32'hFFF0_0091;
        tick();
        total++; if ({dif.o_illegal, dif.o_imm} !== {1'b1, 32'h0}) begin
            bad++; $display("FAIL illegal_lowbits got=%b/%h want=1/0", dif.o_illegal, dif.o_imm);
        end
        dif.i_instr = 32'h0052_8333;
        tick();
        dif.i_valid = 1'b0;
        total++; if (dif.o_rs1_data !== 32'h0000_1234) begin bad++; $display("FAIL rf_readback got=%h want=00001234", dif.o_rs1_data); end
        tick();
    endtask

    task automatic test_reset_mid_stall();
        dif.i_ready = 1'b0;
        dif.i_valid = 1'b1;
        dif.i_pc    = 32'h0000_0400;
        dif.i_instr = 32'h0052_8333;
        tick();
        dif.i_valid = 1'b0;
        total++; if (dif.o_valid !== 1'b1) begin bad++; $display("FAIL mid_stall_valid got=%b want=1", dif.o_valid); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        dif.i_ready = 1'b1;
        total++; if ({dif.o_valid, dif.o_pc} !== {1'b0, 32'h0}) begin
            bad++; $display("FAIL mid_stall_reset got=%b/%h want=0/0", dif.o_valid, dif.o_pc);
        end
        dif.i_valid = 1'b1;
        dif.i_instr = 32'h0052_8333;
        tick();
        total++; if (dif.o_rs1_data !== 32'h0) begin bad++; $display("FAIL rf_reinit_x5 got=%h want=0", dif.o_rs1_data); end
        dif.i_instr = 32'h0001_0093;
        tick();
        dif.i_valid = 1'b0;
        total++; if (dif.o_rs1_data !== 32'h0000_1FFC) begin bad++; $display("FAIL rf_reinit_sp got=%h want=00001ffc", dif.o_rs1_data); end
        tick();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_sp_read();
        test_bypass_and_stall();
        test_flush();
        test_imm();
        test_x0_and_illegal();
        test_reset_mid_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
